// File: rtl/clock_mode_ctrl_pkg.sv
// clock_pkg: mode encoding and blink mask bit positions shared by the clock mode controller
package clock_pkg;
   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_t;
   localparam int BLINK_HOUR = 2;
   localparam int BLINK_MIN  = 1;
   localparam int BLINK_SEC  = 0;
endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: front-panel buttons in, counter enables, mode and blink mask out
interface clock_mode_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic       sec_inc;
   logic       sec_clr;
   logic       min_inc;
   logic       hour_inc;
   logic [1:0] mode;
   logic [2:0] blink_mask;
   modport master (input btn_mode, btn_inc, output sec_inc, sec_clr, min_inc, hour_inc, mode, blink_mask);
   modport slave (output btn_mode, btn_inc, input sec_inc, sec_clr, min_inc, hour_inc, mode, blink_mask);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-count debouncer and one-cycle press pulse
module button_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d, prev_q, prev_d, press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // accept a new level only after DEB_CYCLES consecutive disagreeing samples; press is the delayed rising edge
   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      prev_d  = level_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
         else cnt_d = cnt_q + 1'b1;
      end
      press_d = level_q & ~prev_q;
   end
   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end
   assign level = level_q;
   assign press = press_q;
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN sequencer and blink mask; CLOCK_AUTOREPEAT_EN adds inc auto-repeat
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV      = 50_000_000,
   parameter int DEB_CYCLES    = 1_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input logic              clk,
   input logic              reset_n,
   clock_mode_ctrl_if.master bus
);
   localparam int PW = $clog2(TICK_DIV);
   mode_t state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [2:0] mask_q, mask_d;
   logic blink_q, blink_d, sec_inc_q, sec_inc_d, sec_clr_q, sec_clr_d;
   logic min_inc_q, min_inc_d, hour_inc_q, hour_inc_d;
   logic unused_mode_lvl, mode_p, inc_lvl, inc_p, inc_ev, tick, set_mode;
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
      .clk(clk), .reset_n(reset_n), .btn(bus.btn_mode), .level(unused_mode_lvl), .press(mode_p)
   );
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk(clk), .reset_n(reset_n), .btn(bus.btn_inc), .level(inc_lvl), .press(inc_p)
   );
   assign tick     = pre_q == PW'(TICK_DIV - 1);
   assign set_mode = state_q == MODE_SET_HOUR || state_q == MODE_SET_MIN;
`ifdef CLOCK_AUTOREPEAT_EN
   localparam int RW = $clog2(2 * REPEAT_CYCLES + 1);
   logic [RW-1:0] rep_q, rep_d;
   logic rep_fire, rep_hold;
   // time a held inc since its press: first repeat at 2x the period, then every period; cleared on release or mode change
   always_comb begin
      rep_hold = set_mode && inc_lvl && !mode_p;
      rep_fire = rep_hold && rep_q == RW'(2 * REPEAT_CYCLES);
      rep_d    = !rep_hold ? '0 : inc_p ? RW'(1) : rep_fire ? RW'(REPEAT_CYCLES + 1) : rep_q != '0 ? rep_q + 1'b1 : '0;
   end
   // repeat counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rep_q <= '0;
      else rep_q <= rep_d;
   end
   assign inc_ev = inc_p | rep_fire;
`else
   logic unused_rep;
   assign unused_rep = inc_lvl & (REPEAT_CYCLES > 0);
   assign inc_ev = inc_p;
`endif
   // mode sequencing, counter enables, prescaler restart and blink mask for the coming cycle
   always_comb begin
      state_d    = state_q;
      pre_d      = tick ? '0 : pre_q + 1'b1;
      sec_inc_d  = 1'b0;
      sec_clr_d  = 1'b0;
      min_inc_d  = 1'b0;
      hour_inc_d = 1'b0;
      case (state_q)
         MODE_RUN: if (mode_p) state_d = MODE_SET_HOUR; else sec_inc_d = tick;
         MODE_SET_HOUR: if (mode_p) state_d = MODE_SET_MIN; else hour_inc_d = inc_ev;
         MODE_SET_MIN:
            if (mode_p) begin
               state_d   = MODE_RUN;
               sec_clr_d = 1'b1;
               pre_d     = '0;
            end else min_inc_d = inc_ev;
         default: state_d = MODE_RUN;
      endcase
      blink_d            = blink_q ^ (tick || pre_q == PW'(TICK_DIV / 2 - 1));
      mask_d[BLINK_HOUR] = state_d == MODE_SET_HOUR && blink_d;
      mask_d[BLINK_MIN]  = state_d == MODE_SET_MIN && blink_d;
      mask_d[BLINK_SEC]  = 1'b0;
   end
   // state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= MODE_RUN;
         pre_q      <= '0;
         blink_q    <= 1'b0;
         mask_q     <= '0;
         sec_inc_q  <= 1'b0;
         sec_clr_q  <= 1'b0;
         min_inc_q  <= 1'b0;
         hour_inc_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         blink_q    <= blink_d;
         mask_q     <= mask_d;
         sec_inc_q  <= sec_inc_d;
         sec_clr_q  <= sec_clr_d;
         min_inc_q  <= min_inc_d;
         hour_inc_q <= hour_inc_d;
      end
   end
   assign bus.sec_inc    = sec_inc_q;
   assign bus.sec_clr    = sec_clr_q;
   assign bus.min_inc    = min_inc_q;
   assign bus.hour_inc   = hour_inc_q;
   assign bus.mode       = state_q;
   assign bus.blink_mask = mask_q;
endmodule
